// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel front end: pixel width, frame size,
// streamer FSM states and the skid-buffer entry layout.
package sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int DEF_ROWS = 480;
  localparam int DEF_COLS = 360;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_HBLANK = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             sof;
    logic             eol;
  } entry_t;

endpackage

// File: rtl/sobel_pixel_streamer_skid.sv
// Two-entry valid/ready register stage carrying pixel + sof/eol flags.
// Head register drives the output; the tail register absorbs one stalled push.
module sobel_skid_buffer
  import sobel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output entry_t     data_o,
  output logic       pop_o,
  output logic [1:0] count_o
);

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       pop;

  assign pop = (count_q != 2'd0) && ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        if (count_q != 2'd2) count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Full buffer: shift tail forward and refill it in the same cycle.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign pop_o   = pop;
  assign count_o = count_q;

endmodule

// File: rtl/sobel_pixel_streamer.sv
// Reads a ROWSxCOLS frame from memory and streams it row-major with sof/eol.
// Define SOBEL_SRC_HBLANK_EN to insert HBLANK idle read cycles between rows.
module sobel_pixel_streamer
  import sobel_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ADDR_W = 18,
  parameter int HBLANK = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              ready_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [PIX_W-1:0]  mem_data_i,
  output logic [PIX_W-1:0]  data_o,
  output logic              we_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int HB_W  = ($clog2(HBLANK + 1) < 1) ? 1 : $clog2(HBLANK + 1);
`ifdef SOBEL_SRC_HBLANK_EN
  localparam bit HB_EN = 1'b1;
`else
  localparam bit HB_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [HB_W-1:0]   hb_q, hb_d;
  logic              infl_q, infl_sof_q, infl_eol_q;

  logic       skid_valid, skid_pop;
  logic [1:0] skid_count;
  entry_t     skid_head, push_entry;
  logic [2:0] occ_after;
  logic       issue, last_col, last_row;

  // Committed slots after this cycle's pop; a read may only claim a free one.
  assign occ_after = {1'b0, skid_count} + {2'b0, infl_q} - {2'b0, skid_pop};
  assign issue     = (state_q == ST_STREAM) && (occ_after < 3'd2);
  assign last_col  = (col_q == COL_W'(COLS - 1));
  assign last_row  = (row_q == ROW_W'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    col_d   = col_q;
    hb_d    = hb_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_STREAM;
      ST_STREAM: begin
        if (issue) begin
          if (last_col && last_row) begin
            addr_d  = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = ST_DRAIN;
          end else if (last_col) begin
            addr_d = addr_q + ADDR_W'(1);
            row_d  = row_q + ROW_W'(1);
            col_d  = '0;
            if (HB_EN) begin
              hb_d    = HB_W'(HBLANK - 1);
              state_d = ST_HBLANK;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            col_d  = col_q + COL_W'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (hb_q == '0) state_d = ST_STREAM;
        else            hb_d    = hb_q - HB_W'(1);
      end
      ST_DRAIN: begin
        if (!infl_q && ((skid_count == 2'd0) || (skid_count == 2'd1 && skid_pop)))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      hb_q       <= '0;
      infl_q     <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eol_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      hb_q       <= hb_d;
      infl_q     <= issue;
      infl_sof_q <= issue && (row_q == '0) && (col_q == '0);
      infl_eol_q <= issue && last_col;
    end
  end

  assign push_entry = '{pix: mem_data_i, sof: infl_sof_q, eol: infl_eol_q};

  sobel_skid_buffer u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (infl_q),
    .push_data_i (push_entry),
    .ready_i     (ready_i),
    .valid_o     (skid_valid),
    .data_o      (skid_head),
    .pop_o       (skid_pop),
    .count_o     (skid_count)
  );

  assign mem_en_o     = issue;
  assign mem_addr_o   = addr_q;
  assign data_o       = skid_head.pix;
  assign we_o         = skid_valid;
  assign sof_o        = skid_valid && skid_head.sof;
  assign eol_o        = skid_valid && skid_head.eol;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_sobel_pixel_streamer.sv
// Directed bench for sobel_pixel_streamer: a 4x5 frame instance and a 4x4
// instance whose frame exactly fills its address space.
module tb_sobel_pixel_streamer;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int NPIX = ROWS * COLS;
`ifdef SOBEL_SRC_HBLANK_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, ready1 = 1'b1, mem_en1, we1, sof1, eol1, busy1, done1;
  logic [4:0] addr1;
  logic [7:0] mem_data1 = 8'd0, data1;
  logic [7:0] mem1 [0:31];

  logic       start2 = 1'b0, ready2 = 1'b1, mem_en2, we2, sof2, eol2, busy2, done2;
  logic [3:0] addr2;
  logic [7:0] mem_data2 = 8'd0, data2;
  logic [7:0] mem2 [0:15];

  sobel_pixel_streamer #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(5), .HBLANK(4)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .ready_i(ready1),
    .mem_en_o(mem_en1), .mem_addr_o(addr1), .mem_data_i(mem_data1),
    .data_o(data1), .we_o(we1), .sof_o(sof1), .eol_o(eol1),
    .busy_o(busy1), .frame_done_o(done1)
  );

  sobel_pixel_streamer #(.ROWS(4), .COLS(4), .ADDR_W(4), .HBLANK(4)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .ready_i(ready2),
    .mem_en_o(mem_en2), .mem_addr_o(addr2), .mem_data_i(mem_data2),
    .data_o(data2), .we_o(we2), .sof_o(sof2), .eol_o(eol2),
    .busy_o(busy2), .frame_done_o(done2)
  );

  initial begin
    for (int i = 0; i < 32; i++) mem1[i] = 8'(i);
    for (int i = 0; i < 16; i++) mem2[i] = 8'(100 + i);
  end

  always @(posedge clk) begin
    if (mem_en1) mem_data1 <= mem1[addr1];
    if (mem_en2) mem_data2 <= mem2[addr2];
  end

  int checks = 0;
  int errors = 0;

  int n_acc, done_cnt, done_k, stab_viol, issue_viol, busy_k1, mem_k1, addr_k1;
  int acc_data [64];
  int acc_k    [64];
  int acc_sof  [64];
  int acc_eol  [64];
  logic [7:0] pat = 8'b1001_1011;

  function automatic int exp_k(input int p);
    return 3 + p + GAP * (p / COLS);
  endfunction

  // Drives one frame on dut1 starting in the current interval and records it.
  task automatic run_frame(input bit bp, input int restart_k, input int budget);
    logic [7:0] prev_data;
    bit prev_stall;
    int occ, infl, pop;
    n_acc = 0; done_cnt = 0; done_k = -1; stab_viol = 0; issue_viol = 0;
    busy_k1 = 0; mem_k1 = 0; addr_k1 = -1;
    prev_stall = 0; prev_data = 8'd0; occ = 0; infl = 0;
    start1 = 1'b1;
    ready1 = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start1 = (k == restart_k);
      ready1 = bp ? pat[k % 8] : 1'b1;
      #1;
      if (k == 1) begin
        busy_k1 = busy1; mem_k1 = mem_en1; addr_k1 = addr1;
      end
      pop = (we1 && ready1) ? 1 : 0;
      if (prev_stall && (!we1 || data1 !== prev_data)) stab_viol++;
      if (mem_en1 && (occ + infl - pop) >= 2) issue_viol++;
      if ((occ > 0) != we1) issue_viol++;
      if (pop == 1) begin
        if (n_acc < 64) begin
          acc_data[n_acc] = data1; acc_k[n_acc] = k;
          acc_sof[n_acc] = sof1;   acc_eol[n_acc] = eol1;
        end
        n_acc++;
      end
      if (done1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      occ = occ + infl - pop;
      infl = mem_en1 ? 1 : 0;
      prev_stall = we1 && !ready1;
      prev_data = data1;
    end
    start1 = 1'b0;
    ready1 = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_en1, addr1, data1, we1, sof1, eol1, busy1, done1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected all zero",
               {mem_en1, addr1, data1, we1, sof1, eol1, busy1, done1});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy1, we1, mem_en1, busy2, we2, mem_en2} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b expected 000000",
               {busy1, we1, mem_en1, busy2, we2, mem_en2});
    end
  endtask

  task automatic test_basic;
    run_frame(1'b0, 0, 50);
    checks++;
    if (mem_k1 !== 1 || addr_k1 !== 0) begin
      errors++; $display("FAIL first_read got en=%0d addr=%0d expected en=1 addr=0", mem_k1, addr_k1);
    end
    checks++;
    if (busy_k1 !== 1) begin errors++; $display("FAIL busy_after_start got %0d expected 1", busy_k1); end
    checks++;
    if (n_acc !== NPIX) begin errors++; $display("FAIL basic_count got %0d expected %0d", n_acc, NPIX); end
    for (int p = 0; p < NPIX && p < n_acc; p++) begin
      checks++;
      if (acc_data[p] !== p || acc_k[p] !== exp_k(p)) begin
        errors++;
        $display("FAIL basic_pixel p=%0d got data=%0d cyc=%0d expected data=%0d cyc=%0d",
                 p, acc_data[p], acc_k[p], p, exp_k(p));
      end
      checks++;
      if (acc_sof[p] !== (p == 0 ? 1 : 0) || acc_eol[p] !== (p % COLS == COLS - 1 ? 1 : 0)) begin
        errors++;
        $display("FAIL basic_flags p=%0d got sof=%0d eol=%0d", p, acc_sof[p], acc_eol[p]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_k !== 3 + NPIX + GAP * (ROWS - 1)) begin
      errors++;
      $display("FAIL basic_done got count=%0d cyc=%0d expected count=1 cyc=%0d",
               done_cnt, done_k, 3 + NPIX + GAP * (ROWS - 1));
    end
    checks++;
    if (busy1 !== 1'b0 || addr1 !== 5'd0) begin
      errors++; $display("FAIL basic_idle got busy=%0d addr=%0d expected 0 0", busy1, addr1);
    end
  endtask

  task automatic test_backpressure;
    run_frame(1'b1, 0, 200);
    checks++;
    if (n_acc !== NPIX) begin errors++; $display("FAIL bp_count got %0d expected %0d", n_acc, NPIX); end
    for (int p = 0; p < NPIX && p < n_acc; p++) begin
      checks++;
      if (acc_data[p] !== p || acc_sof[p] !== (p == 0 ? 1 : 0) ||
          acc_eol[p] !== (p % COLS == COLS - 1 ? 1 : 0)) begin
        errors++;
        $display("FAIL bp_pixel p=%0d got data=%0d sof=%0d eol=%0d expected data=%0d",
                 p, acc_data[p], acc_sof[p], acc_eol[p], p);
      end
    end
    checks++;
    if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d violations expected 0", stab_viol); end
    checks++;
    if (issue_viol !== 0) begin errors++; $display("FAIL bp_no_overissue got %0d violations expected 0", issue_viol); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL bp_done got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_restart_ignored;
    run_frame(1'b0, 6, 50);
    checks++;
    if (n_acc !== NPIX) begin errors++; $display("FAIL restart_count got %0d expected %0d", n_acc, NPIX); end
    for (int p = 0; p < NPIX && p < n_acc; p++) begin
      checks++;
      if (acc_data[p] !== p) begin
        errors++; $display("FAIL restart_pixel p=%0d got %0d expected %0d", p, acc_data[p], p);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_k !== 3 + NPIX + GAP * (ROWS - 1)) begin
      errors++;
      $display("FAIL restart_done got count=%0d cyc=%0d expected count=1 cyc=%0d",
               done_cnt, done_k, 3 + NPIX + GAP * (ROWS - 1));
    end
  endtask

  task automatic test_reset_mid;
    int early_done;
    early_done = 0;
    start1 = 1'b1;
    ready1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (k == 7) rst = 1'b1;
      #1;
      if (done1) early_done++;
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mem_en1, addr1, data1, we1, sof1, eol1, busy1, done1} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b expected all zero",
               {mem_en1, addr1, data1, we1, sof1, eol1, busy1, done1});
    end
    rst = 1'b0;
    run_frame(1'b0, 0, 40);
    checks++;
    if (n_acc < 1 || acc_data[0] !== 0 || acc_sof[0] !== 1 || acc_k[0] !== 3) begin
      errors++;
      $display("FAIL midreset_restart got n=%0d data=%0d sof=%0d cyc=%0d expected data=0 sof=1 cyc=3",
               n_acc, acc_data[0], acc_sof[0], acc_k[0]);
    end
    checks++;
    if (early_done + done_cnt !== 1 || n_acc !== NPIX) begin
      errors++;
      $display("FAIL midreset_done got pulses=%0d pixels=%0d expected 1 and %0d",
               early_done + done_cnt, n_acc, NPIX);
    end
  endtask

  task automatic test_pow2_frame;
    int issues, last_addr, addr_bad, n2, pix_bad, d2k;
    issues = 0; last_addr = -1; addr_bad = 0; n2 = 0; pix_bad = 0; d2k = -1;
    start2 = 1'b1;
    ready2 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      #1;
      if (mem_en2) begin
        if (addr2 !== 4'(issues)) addr_bad++;
        last_addr = addr2;
        issues++;
      end
      if (we2) begin
        if (data2 !== 8'(100 + n2)) pix_bad++;
        n2++;
      end
      if (done2 && d2k < 0) d2k = k;
    end
    checks++;
    if (issues !== 16 || last_addr !== 15 || addr_bad !== 0) begin
      errors++;
      $display("FAIL pow2_addr got issues=%0d last=%0d bad=%0d expected 16 15 0", issues, last_addr, addr_bad);
    end
    checks++;
    if (n2 !== 16 || pix_bad !== 0) begin
      errors++; $display("FAIL pow2_pixels got n=%0d bad=%0d expected 16 0", n2, pix_bad);
    end
    checks++;
    if (d2k !== 3 + 16 + GAP * 3) begin
      errors++; $display("FAIL pow2_done got cyc=%0d expected %0d", d2k, 3 + 16 + GAP * 3);
    end
    checks++;
    if (addr2 !== 4'd0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL pow2_idle got addr=%0d busy=%0d expected 0 0", addr2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_pow2_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
